sfu_dispatcher: RTL and testbench

SFU_DISPATCHER -- requirements
Module: sfu_dispatcher

---
 rtl/sfu_dispatcher_if.sv | 45 ++++
 rtl/sfu_dispatcher.sv | 159 +++++++++++++++
 tb/tb_sfu_dispatcher.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sfu_dispatcher_if.sv
// Command, source-buffer, SFU and result-buffer signals of the SFU dispatcher.
// master is the dispatcher's view; slave is the surrounding system's view.
interface sfu_dispatcher_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_len;
    logic [3:0]  cmd_mode;
    logic [7:0]  cmd_q;

    logic        src_rd_en;
    logic [5:0]  src_rd_addr;
    logic [31:0] src_rd_data;

    logic        sfu_req;
    logic [5:0]  sfu_cfg_len;
    logic [3:0]  sfu_cfg_mode;
    logic [7:0]  sfu_q;
    logic [31:0] sfu_data;

    logic [31:0] sfu_data_out;
    logic        sfu_valid_out;
    logic        sfu_calc_ok;

    logic        dst_wr_en;
    logic [5:0]  dst_wr_addr;
    logic [31:0] dst_wr_data;

    logic        done;
    logic        err_timeout;
    logic        err_ovf;

    modport master (
        input  cmd_valid, cmd_len, cmd_mode, cmd_q, src_rd_data,
               sfu_data_out, sfu_valid_out, sfu_calc_ok,
        output cmd_ready, src_rd_en, src_rd_addr, sfu_req, sfu_cfg_len, sfu_cfg_mode, sfu_q,
               sfu_data, dst_wr_en, dst_wr_addr, dst_wr_data, done, err_timeout, err_ovf
    );

    modport slave (
        output cmd_valid, cmd_len, cmd_mode, cmd_q, src_rd_data,
               sfu_data_out, sfu_valid_out, sfu_calc_ok,
        input  cmd_ready, src_rd_en, src_rd_addr, sfu_req, sfu_cfg_len, sfu_cfg_mode, sfu_q,
               sfu_data, dst_wr_en, dst_wr_addr, dst_wr_data, done, err_timeout, err_ovf
    );
endinterface

// File: rtl/sfu_dispatcher.sv
// Streams len+1 source words into the SFU, writes its result beats to the
// destination buffer, and reports completion, timeout and result overflow.
module sfu_dispatcher (
    input logic              clk,
    input logic              rst_n,
    sfu_dispatcher_if.master bus
);

    typedef enum logic [2:0] {StIdle, StPref, StFeed, StWait, StFin} state_e;

    state_e      state_q, state_d;
    logic [5:0]  len_q, len_d;
    logic [3:0]  mode_q, mode_d;
    logic [7:0]  qv_q, qv_d;
    logic [5:0]  k_q, k_d;
    logic [6:0]  res_cnt_q, res_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        calc_q, calc_d;
    logic        err_to_q, err_to_d;
    logic        err_ovf_q, err_ovf_d;
    logic        ready_q, ready_d;
    logic [31:0] data_q, data_d;
    logic        wr_en_q, wr_en_d;
    logic [5:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;

    logic hs, collect, beat, in_range;

    assign hs       = bus.cmd_valid & ready_q;
    assign collect  = (state_q == StFeed) | (state_q == StWait) | (state_q == StFin);
    assign beat     = collect & bus.sfu_valid_out;
    assign in_range = res_cnt_q <= {1'b0, len_q};

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        mode_d     = mode_q;
        qv_d       = qv_q;
        k_d        = k_q;
        res_cnt_d  = res_cnt_q;
        wait_cnt_d = wait_cnt_q;
        calc_d     = calc_q;
        err_to_d   = err_to_q;
        err_ovf_d  = err_ovf_q;
        data_d     = data_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        unique case (state_q)
            StIdle: begin
                if (hs) begin
                    len_d      = bus.cmd_len;
                    mode_d     = bus.cmd_mode;
                    qv_d       = bus.cmd_q;
                    k_d        = 6'd0;
                    res_cnt_d  = 7'd0;
                    wait_cnt_d = 8'd0;
                    calc_d     = 1'b0;
                    err_to_d   = 1'b0;
                    err_ovf_d  = 1'b0;
                    state_d    = StPref;
                end
            end
            StPref: state_d = StFeed;
            StFeed: begin
                // Keep the last element so sfu_data holds it through WAIT.
                data_d = bus.src_rd_data;
                if (k_q == len_q) begin
                    state_d = StWait;
                end else begin
                    k_d = k_q + 6'd1;
                end
            end
            StWait: begin
                if (calc_q) begin
                    state_d = StFin;
                end else if (wait_cnt_q == 8'hff) begin
                    err_to_d = 1'b1;
                    state_d  = StFin;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (collect && bus.sfu_calc_ok) begin
            calc_d = 1'b1;
        end

        if (beat) begin
            if (in_range) begin
                wr_en_d   = 1'b1;
                wr_addr_d = res_cnt_q[5:0];
                wr_data_d = bus.sfu_data_out;
                res_cnt_d = res_cnt_q + 7'd1;
            end else begin
                err_ovf_d = 1'b1;
            end
        end

        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            len_q      <= '0;
            mode_q     <= '0;
            qv_q       <= '0;
            k_q        <= '0;
            res_cnt_q  <= '0;
            wait_cnt_q <= '0;
            calc_q     <= 1'b0;
            err_to_q   <= 1'b0;
            err_ovf_q  <= 1'b0;
            ready_q    <= 1'b0;
            data_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            mode_q     <= mode_d;
            qv_q       <= qv_d;
            k_q        <= k_d;
            res_cnt_q  <= res_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            calc_q     <= calc_d;
            err_to_q   <= err_to_d;
            err_ovf_q  <= err_ovf_d;
            ready_q    <= ready_d;
            data_q     <= data_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Source reads run one address ahead of the element currently on sfu_data.
    assign bus.cmd_ready    = ready_q;
    assign bus.src_rd_en    = (state_q == StPref) | ((state_q == StFeed) & (k_q != len_q));
    assign bus.src_rd_addr  = (state_q == StFeed) ? (k_q + 6'd1) : 6'd0;
    assign bus.sfu_req      = (state_q == StFeed) & (k_q == 6'd0);
    assign bus.sfu_cfg_len  = len_q;
    assign bus.sfu_cfg_mode = mode_q;
    assign bus.sfu_q        = qv_q;
    assign bus.sfu_data     = (state_q == StFeed) ? bus.src_rd_data : data_q;
    assign bus.dst_wr_en    = wr_en_q;
    assign bus.dst_wr_addr  = wr_addr_q;
    assign bus.dst_wr_data  = wr_data_q;
    assign bus.done         = (state_q == StFin);
    assign bus.err_timeout  = err_to_q;
    assign bus.err_ovf      = err_ovf_q;

endmodule

// File: tb/tb_sfu_dispatcher.sv
// Directed bench for sfu_dispatcher: operand and result-write scoreboards
// checked by a negedge monitor, plus per-command completion checks.
module tb_sfu_dispatcher;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sfu_dispatcher_if bus ();

    sfu_dispatcher dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [64];
    logic [31:0] exp_ops [$];
    logic [37:0] exp_wr [$];
    logic [5:0]  cur_len;
    logic [3:0]  cur_mode;
    logic [7:0]  cur_q;
    int          feed_left = 0;
    int          req_cnt = 0;
    int          done_cnt = 0;
    int          rd_cnt = 0;
    logic [5:0]  last_rd_addr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Synchronous source buffer: data appears the cycle after the read.
    always @(posedge clk) begin
        if (bus.src_rd_en) begin
            bus.src_rd_data <= mem[bus.src_rd_addr];
            rd_cnt          <= rd_cnt + 1;
            last_rd_addr    <= bus.src_rd_addr;
        end
    end

    task automatic check_op(input string name);
        logic [31:0] e;
        if (exp_ops.size() == 0) begin
            check("op_unexpected", 64'(exp_ops.size()), 64'd1);
        end else begin
            e = exp_ops.pop_front();
            check(name, bus.sfu_data, e);
            check("sfu_cfg", {bus.sfu_cfg_len, bus.sfu_cfg_mode, bus.sfu_q},
                  {cur_len, cur_mode, cur_q});
        end
    endtask

    always @(negedge clk) begin
        logic [37:0] w;
        if (!rst_n) begin
            feed_left <= 0;
        end else begin
            if (bus.sfu_req) begin
                req_cnt <= req_cnt + 1;
                check_op("sfu_op0");
                feed_left <= int'(cur_len);
            end else if (feed_left > 0) begin
                check_op("sfu_opk");
                feed_left <= feed_left - 1;
            end
            if (bus.dst_wr_en) begin
                if (exp_wr.size() == 0) begin
                    check("dst_unexpected_write", bus.dst_wr_en, 64'd0);
                end else begin
                    w = exp_wr.pop_front();
                    check("dst_write", {bus.dst_wr_addr, bus.dst_wr_data}, w);
                end
            end
            if (bus.done) done_cnt <= done_cnt + 1;
        end
    end

    function automatic logic [31:0] res_word(input logic [31:0] base, input int i);
        return (base ^ 32'h5a5a_0000) + 32'(i);
    endfunction

    task automatic run_cmd(input string tag, input int len, input logic [3:0] mode,
                           input logic [7:0] q, input int nbeats, input bit send_calc,
                           input bit calc_early, input bit exp_ovf, input bit exp_to,
                           input logic [31:0] base);
        int rd0, rq0, dn0, cyc;
        bit got;
        for (int i = 0; i < 64; i++) mem[i] = base + 32'(i);
        for (int i = 0; i <= len; i++) exp_ops.push_back(base + 32'(i));
        for (int i = 0; i < nbeats && i <= len; i++) exp_wr.push_back({6'(i), res_word(base, i)});
        cur_len  = 6'(len);
        cur_mode = mode;
        cur_q    = q;
        rd0 = rd_cnt;
        rq0 = req_cnt;
        dn0 = done_cnt;

        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (bus.cmd_ready) got = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check({tag, "_ready_wait"}, 64'(got), 64'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 6'(len);
        bus.cmd_mode  = mode;
        bus.cmd_q     = q;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;

        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            if (bus.sfu_req) got = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check({tag, "_req_seen"}, 64'(got), 64'd1);

        for (int i = 0; i < nbeats; i++) begin
            bus.sfu_valid_out = 1'b1;
            bus.sfu_data_out  = res_word(base, i);
            bus.sfu_calc_ok   = calc_early && (i == 0);
            @(posedge clk);
            #1;
        end
        bus.sfu_valid_out = 1'b0;
        bus.sfu_calc_ok   = 1'b0;
        if (send_calc && !calc_early) begin
            bus.sfu_calc_ok = 1'b1;
            @(posedge clk);
            #1;
            bus.sfu_calc_ok = 1'b0;
        end

        cyc = 0;
        got = 0;
        while (cyc < 400 && !got) begin
            if (bus.done) got = 1;
            else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        if (exp_to) check({tag, "_timeout_latency"}, 64'(cyc >= 250), 64'd1);

        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_count"}, 64'(done_cnt - dn0), 64'd1);
        check({tag, "_req_count"}, 64'(req_cnt - rq0), 64'd1);
        check({tag, "_src_reads"}, 64'(rd_cnt - rd0), 64'(len + 1));
        check({tag, "_err_ovf"}, bus.err_ovf, 64'(exp_ovf));
        check({tag, "_err_timeout"}, bus.err_timeout, 64'(exp_to));
        check({tag, "_writes_left"}, 64'(exp_wr.size()), 64'd0);
        check({tag, "_ops_left"}, 64'(exp_ops.size()), 64'd0);
        check({tag, "_ready_after"}, bus.cmd_ready, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn0;
        bit got;
        bus.cmd_valid     = 1'b0;
        bus.cmd_len       = '0;
        bus.cmd_mode      = '0;
        bus.cmd_q         = '0;
        bus.sfu_data_out  = '0;
        bus.sfu_valid_out = 1'b0;
        bus.sfu_calc_ok   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {bus.cmd_ready, bus.src_rd_en, bus.sfu_req, bus.dst_wr_en,
              bus.done, bus.err_timeout, bus.err_ovf, bus.sfu_data, bus.sfu_cfg_len}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", bus.cmd_ready, 64'd1);

        run_cmd("basic", 3, 4'd1, 8'h10, 4, 1'b1, 1'b0, 1'b0, 1'b0, 32'ha000_0000);
        run_cmd("len0", 0, 4'd2, 8'h22, 1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hb000_0000);
        check("len0_rd_addr", last_rd_addr, 64'd0);
        run_cmd("ovf", 1, 4'd3, 8'h33, 3, 1'b1, 1'b0, 1'b1, 1'b0, 32'hc000_0000);
        run_cmd("timeout", 0, 4'd4, 8'h44, 1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hd000_0000);
        run_cmd("early_calc", 3, 4'd5, 8'h55, 4, 1'b1, 1'b1, 1'b0, 1'b0, 32'he000_0000);

        // Reset in the middle of FEED.
        for (int i = 0; i < 64; i++) mem[i] = 32'h1234_0000 + 32'(i);
        for (int i = 0; i <= 5; i++) exp_ops.push_back(32'h1234_0000 + 32'(i));
        cur_len  = 6'd5;
        cur_mode = 4'd6;
        cur_q    = 8'h66;
        dn0 = done_cnt;
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 6'd5;
        bus.cmd_mode  = 4'd6;
        bus.cmd_q     = 8'h66;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            if (bus.sfu_req) got = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("rst_req_seen", 64'(got), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", {bus.cmd_ready, bus.src_rd_en, bus.sfu_req, bus.dst_wr_en,
              bus.done, bus.err_timeout, bus.err_ovf, bus.sfu_data, bus.sfu_cfg_len}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_ops.delete();
        repeat (10) @(posedge clk);
        #1;
        check("rst_no_done", 64'(done_cnt - dn0), 64'd0);
        check("rst_ready", bus.cmd_ready, 64'd1);

        run_cmd("post_rst", 2, 4'd7, 8'h77, 3, 1'b1, 1'b0, 1'b0, 1'b0, 32'hf000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
